bus_region_decoder: RTL and testbench

Parametrised CPU bus decoder and read-data return mux for the v65C02 system. It replaces hard-coded per-device address decoding and the fixed one-cycle return pipeline with N configurable base/mask regions and per-region wait states driven through the CPU `RDY` input. It also latches the first unmapped access for debug. It sits between the `cpu_65c02` bus (`AB`/`DI`/`WE`/`RDY`) and the RAM, ROM, VGA and seven-segment slaves.

---
 rtl/bus_region_pkg.sv | 24 ++
 rtl/addr_region_match.sv | 23 ++
 rtl/bus_region_decoder.sv | 118 +++++++++++
 tb/tb_bus_region_decoder.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/bus_region_pkg.sv
// Shared constants for the v65C02 bus region decoder: select codes, FSM states
// and the stock memory map.
package bus_region_pkg;

  localparam int SEL_W = 4;
  localparam logic [SEL_W-1:0] SEL_NONE = 4'hF;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  localparam logic [15:0] RAM_BASE  = 16'h0000;
  localparam logic [15:0] RAM_MASK  = 16'h8000;
  localparam logic [15:0] BIOS_BASE = 16'hC000;
  localparam logic [15:0] BIOS_MASK = 16'hC000;
  localparam logic [15:0] VRAM_BASE = 16'h8000;
  localparam logic [15:0] VRAM_MASK = 16'hF000;
  localparam logic [15:0] VGA_BASE  = 16'h9000;
  localparam logic [15:0] VGA_MASK  = 16'hFF00;
  localparam logic [15:0] SSEG_BASE = 16'h9100;
  localparam logic [15:0] SSEG_MASK = 16'hFF00;

endpackage

// File: rtl/addr_region_match.sv
// Combinational base/mask priority encoder; the lowest matching region wins.
module addr_region_match
  import bus_region_pkg::*;
#(
  parameter int N_REGIONS = 4,
  parameter logic [16*N_REGIONS-1:0] REGION_BASE = 64'h9100_9000_C000_0000,
  parameter logic [16*N_REGIONS-1:0] REGION_MASK = 64'hFF00_F000_C000_8000
) (
  input  logic [15:0]      addr_i,
  output logic [SEL_W-1:0] sel_o
);

  // Scanning from the top down lets the lowest index overwrite higher ones.
  always_comb begin
    sel_o = SEL_NONE;
    for (int i = N_REGIONS - 1; i >= 0; i--) begin
      if ((addr_i & REGION_MASK[16*i +: 16]) == REGION_BASE[16*i +: 16]) begin
        sel_o = SEL_W'(i);
      end
    end
  end

endmodule

// File: rtl/bus_region_decoder.sv
// CPU bus decoder with per-region wait states via RDY, registered read-data
// return mux and a sticky capture of the first unmapped access.
module bus_region_decoder
  import bus_region_pkg::*;
#(
  parameter int N_REGIONS = 4,
  parameter logic [16*N_REGIONS-1:0] REGION_BASE = 64'h9100_9000_C000_0000,
  parameter logic [16*N_REGIONS-1:0] REGION_MASK = 64'hFF00_F000_C000_8000,
  parameter logic [3*N_REGIONS-1:0]  REGION_WAIT = 12'h000,
  parameter logic [7:0]              DEFAULT_DATA = 8'h00
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [15:0]            addr_i,
  input  logic                   we_i,
  input  logic [8*N_REGIONS-1:0] din_i,
  output logic [N_REGIONS-1:0]   en_o,
  output logic                   we_o,
  output logic [7:0]             dout_o,
  output logic                   rdy_o,
  input  logic                   clr_unmapped_i,
  output logic                   unmapped_o,
  output logic [15:0]            unmapped_addr_o,
  output logic                   dbg_state_o
);

  state_t           r_state;
  logic [2:0]       r_cnt;
  logic [SEL_W-1:0] r_sel;
  logic             r_unmapped;
  logic [15:0]      r_unmapped_addr;

  logic [SEL_W-1:0] w_sel;
  logic [2:0]       w_wait;
  logic             w_idle;
  logic             w_none;

  addr_region_match #(
    .N_REGIONS  (N_REGIONS),
    .REGION_BASE(REGION_BASE),
    .REGION_MASK(REGION_MASK)
  ) u_match (
    .addr_i(addr_i),
    .sel_o (w_sel)
  );

  assign w_idle = (r_state == ST_IDLE);
  assign w_none = (w_sel == SEL_NONE);

  always_comb begin
    w_wait = 3'd0;
    en_o   = '0;
    for (int i = 0; i < N_REGIONS; i++) begin
      if (w_sel == SEL_W'(i)) begin
        w_wait  = REGION_WAIT[3*i +: 3];
        en_o[i] = w_idle;
      end
    end
  end

  // Slaves only see a strobe on the start cycle, so a write commits once.
  assign we_o = we_i & w_idle;

  always_comb begin
    dout_o = DEFAULT_DATA;
    for (int i = 0; i < N_REGIONS; i++) begin
      if (r_sel == SEL_W'(i)) begin
        dout_o = din_i[8*i +: 8];
      end
    end
  end

  assign rdy_o           = w_idle;
  assign unmapped_o      = r_unmapped;
  assign unmapped_addr_o = r_unmapped_addr;
  assign dbg_state_o     = r_state;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
      r_cnt   <= 3'd0;
      r_sel   <= SEL_NONE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_sel <= w_sel;
          if (w_wait != 3'd0) begin
            r_state <= ST_WAIT;
            r_cnt   <= w_wait;
          end
        end
        default: begin
          r_cnt <= r_cnt - 3'd1;
          if (r_cnt == 3'd1) begin
            r_state <= ST_IDLE;
          end
        end
      endcase
    end
  end

  // A new unmapped access on the same edge as a clear re-arms and captures.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_unmapped      <= 1'b0;
      r_unmapped_addr <= 16'h0000;
    end else if (w_idle && w_none) begin
      r_unmapped <= 1'b1;
      if (!r_unmapped || clr_unmapped_i) begin
        r_unmapped_addr <= addr_i;
      end
    end else if (clr_unmapped_i) begin
      r_unmapped      <= 1'b0;
      r_unmapped_addr <= 16'h0000;
    end
  end

endmodule

// File: tb/tb_bus_region_decoder.sv
// Directed bench for bus_region_decoder: five-region map with overlap, wait
// states, unmapped capture and reset during a wait.
module tb_bus_region_decoder;

  localparam int N = 5;
  // r0 RAM 0000/8000 W0, r1 9000/F000 W0, r2 9000/FF00 W0 (shadowed by r1),
  // r3 ROM C000/C000 W3, r4 B000/F000 W5
  localparam logic [16*N-1:0] BASE = {16'hB000, 16'hC000, 16'h9000, 16'h9000, 16'h0000};
  localparam logic [16*N-1:0] MASK = {16'hF000, 16'hC000, 16'hFF00, 16'hF000, 16'h8000};
  localparam logic [3*N-1:0]  WAIT = {3'd5, 3'd3, 3'd0, 3'd0, 3'd0};

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [15:0]    addr = 16'h0000;
  logic           we = 1'b0;
  logic [8*N-1:0] din = {8'hB4, 8'hC3, 8'h92, 8'h91, 8'h5A};
  logic [N-1:0]   en;
  logic           we_out;
  logic [7:0]     dout;
  logic           rdy;
  logic           clr = 1'b0;
  logic           unmapped;
  logic [15:0]    unmapped_addr;
  logic           dbg_state;

  logic           start = 1'b0;
  logic [7:0]     exp_q[$];
  int             checks = 0;
  int             errors = 0;

  bus_region_decoder #(
    .N_REGIONS   (N),
    .REGION_BASE (BASE),
    .REGION_MASK (MASK),
    .REGION_WAIT (WAIT),
    .DEFAULT_DATA(8'h00)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .addr_i         (addr),
    .we_i           (we),
    .din_i          (din),
    .en_o           (en),
    .we_o           (we_out),
    .dout_o         (dout),
    .rdy_o          (rdy),
    .clr_unmapped_i (clr),
    .unmapped_o     (unmapped),
    .unmapped_addr_o(unmapped_addr),
    .dbg_state_o    (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: a response is due on the first rdy=1 cycle after an accepted start.
  initial begin
    logic pending;
    logic [7:0] e;
    pending = 1'b0;
    forever begin
      @(negedge clk);
      if (pending && rdy) begin
        pending = 1'b0;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL rdata: response with empty expected queue, got %h", dout);
        end else begin
          e = exp_q.pop_front();
          if (dout !== e) begin
            errors++;
            $display("FAIL rdata: got %h expected %h", dout, e);
          end
        end
      end
      if (start && rdy) pending = 1'b1;
    end
  end

  // Call just after a rising edge with the DUT idle; returns just after a rising edge.
  task automatic access(input logic [15:0] a, input logic w, input logic [7:0] exp_d,
                        input logic [N-1:0] exp_en, input int exp_wait);
    int waits;
    int we_hi;
    addr  = a;
    we    = w;
    start = 1'b1;
    exp_q.push_back(exp_d);
    @(negedge clk);
    chk("start_en", 16'(en), 16'(exp_en));
    chk("start_rdy", 16'(rdy), 16'h1);
    we_hi = we_out ? 1 : 0;
    @(posedge clk);
    #1;
    start = 1'b0;
    we    = 1'b0;
    clr   = 1'b0;
    addr  = 16'h0000;
    waits = 0;
    forever begin
      @(negedge clk);
      if (we_out) we_hi++;
      if (rdy) break;
      if (en !== '0) begin
        checks++;
        errors++;
        $display("FAIL wait_en: got %b expected 0", en);
      end
      waits++;
      if (waits > 20) begin
        checks++;
        errors++;
        $display("FAIL timeout: rdy low for %0d cycles", waits);
        break;
      end
    end
    chk("wait_cycles", 16'(waits), 16'(exp_wait));
    chk("we_pulses", 16'(we_hi), w ? 16'h1 : 16'h0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    // reset state
    #12;
    chk("rst_rdy", 16'(rdy), 16'h1);
    chk("rst_dout", 16'(dout), 16'h00);
    chk("rst_unmapped", 16'(unmapped), 16'h0);
    chk("rst_uaddr", unmapped_addr, 16'h0000);
    chk("rst_state", 16'(dbg_state), 16'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    access(16'h0010, 1'b0, 8'h5A, 5'b00001, 0);  // RAM, no wait
    access(16'h9005, 1'b0, 8'h91, 5'b00010, 0);  // r1 beats overlapping r2
    access(16'hC123, 1'b0, 8'hC3, 5'b01000, 3);  // ROM, 3 wait states
    access(16'hC010, 1'b1, 8'hC3, 5'b01000, 3);  // write with waits: one strobe
    access(16'h0020, 1'b1, 8'h5A, 5'b00001, 0);

    // unmapped capture
    access(16'hA000, 1'b0, 8'h00, 5'b00000, 0);
    chk("unm_flag1", 16'(unmapped), 16'h1);
    chk("unm_addr1", unmapped_addr, 16'hA000);
    access(16'hA100, 1'b0, 8'h00, 5'b00000, 0);
    chk("unm_addr_sticky", unmapped_addr, 16'hA000);
    clr = 1'b1;
    access(16'hA200, 1'b0, 8'h00, 5'b00000, 0);
    chk("unm_clr_set_flag", 16'(unmapped), 16'h1);
    chk("unm_clr_set_addr", unmapped_addr, 16'hA200);
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    chk("unm_clr_flag", 16'(unmapped), 16'h0);
    chk("unm_clr_addr", unmapped_addr, 16'h0000);

    // reset in the second wait cycle of a W=5 access
    access(16'hA300, 1'b0, 8'h00, 5'b00000, 0);
    addr = 16'hB000;
    @(posedge clk);
    #1;
    addr = 16'h0000;
    chk("mid_wait_rdy", 16'(rdy), 16'h0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("rst_wait_rdy", 16'(rdy), 16'h1);
    chk("rst_wait_dout", 16'(dout), 16'h00);
    chk("rst_wait_unm", 16'(unmapped), 16'h0);
    chk("rst_wait_uaddr", unmapped_addr, 16'h0000);
    @(posedge clk);
    #1;
    rst = 1'b0;
    access(16'h0030, 1'b0, 8'h5A, 5'b00001, 0);
    access(16'hB010, 1'b0, 8'hB4, 5'b10000, 5);

    repeat (3) @(posedge clk);
    chk("queue_drained", 16'(exp_q.size()), 16'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
